// File: rtl/data_memory_unit.sv
// rtl/data_memory_unit.sv - handshaked byte-addressed data memory for the load/store stage
module data_memory_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_error
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int OB = $clog2(NB);
  localparam int IW = $clog2(DEPTH);
  localparam int WW = ADDR_WIDTH - OB;
  localparam logic [WW-1:0] DEPTH_W = WW'(DEPTH);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                state_q, state_d;
  logic                  write_q;
  logic [1:0]            size_q;
  logic                  unsigned_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rword_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  accept;
  logic [OB-1:0]         off;
  logic [WW-1:0]         widx;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  bad_size;
  logic                  err;
  logic [NB-1:0]         be_base;
  logic [NB-1:0]         be;
  logic [DATA_WIDTH-1:0] wdata_sh;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] rd_sh;
  logic [DATA_WIDTH-1:0] keep;
  logic                  msb;
  logic [DATA_WIDTH-1:0] ext;

  assign off  = addr_q[OB-1:0];
  assign widx = addr_q[ADDR_WIDTH-1:OB];

  // Error classification and lane selection from the latched request
  always_comb begin
    misaligned = 1'b0;
    be_base    = '0;
    case (size_q)
      2'b00: begin misaligned = 1'b0;       be_base = NB'(1);  end
      2'b01: begin misaligned = off[0];     be_base = NB'(3);  end
      2'b10: begin misaligned = |off[1:0];  be_base = NB'(15); end
      default: begin misaligned = |off;     be_base = '1;      end
    endcase
    out_of_range = (widx >= DEPTH_W);
    bad_size     = (size_q == 2'b11) && (DATA_WIDTH == 32);
    err          = misaligned || out_of_range || bad_size;
    be           = be_base << off;
    wdata_sh     = wdata_q << {off, 3'b000};
    mem_we       = (state_q == ACCESS) && write_q && !err;
  end

  // Next-state logic; only IDLE advertises readiness
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = ACCESS;
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign accept = req_valid && req_ready;

  // State register, request latch and load-word capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      write_q    <= 1'b0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rword_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        write_q    <= req_write;
        size_q     <= req_size;
        unsigned_q <= req_unsigned;
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
      end
      if (state_q == ACCESS && !write_q && !err) begin
        rword_q <= mem_q[widx[IW-1:0]];
      end
    end
  end

  // Byte-lane store; reset forces IDLE so an interrupted store never commits
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) mem_q[widx[IW-1:0]][b*8 +: 8] <= wdata_sh[b*8 +: 8];
      end
    end
  end

  // Right-align the captured word and extend to full width
  always_comb begin
    rd_sh = rword_q >> {off, 3'b000};
    keep  = '1;
    msb   = rd_sh[DATA_WIDTH-1];
    case (size_q)
      2'b00: begin keep = DATA_WIDTH'(8'hFF);         msb = rd_sh[7];  end
      2'b01: begin keep = DATA_WIDTH'(16'hFFFF);      msb = rd_sh[15]; end
      2'b10: begin keep = DATA_WIDTH'(32'hFFFF_FFFF); msb = rd_sh[31]; end
      default: begin keep = '1;                       msb = rd_sh[DATA_WIDTH-1]; end
    endcase
    ext = (rd_sh & keep) | ((msb && !unsigned_q) ? ~keep : '0);
  end

  // Response outputs are zero outside the single RESP cycle
  always_comb begin
    resp_valid = (state_q == RESP);
    resp_error = resp_valid && err;
    resp_rdata = (resp_valid && !err && !write_q) ? ext : '0;
  end

endmodule
